// File: rtl/mem_wait_responder.sv
// Single-ported word RAM behind a valid/ready request/response handshake.
// Each access spends a programmable number of wait states before it commits.
module mem_wait_responder #(
    parameter int    DEPTH_WORDS = 256,
    parameter int    WAIT_CYCLES = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW      = $clog2(DEPTH_WORDS);
    localparam logic [31:0] DEPTH_U = DEPTH_WORDS;

    generate
        if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
            $error("mem_wait_responder: WAIT_CYCLES must be within 0..15");
        end
        if (DEPTH_WORDS < 4 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
            $error("mem_wait_responder: DEPTH_WORDS must be a power of two >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        mem_we;
    logic        access_err;
    logic [AW-1:0] word_idx;

    logic [31:0] mem_q [DEPTH_WORDS];

    assign word_idx   = addr_q[AW+1:2];
    assign access_err = (addr_q[1:0] != 2'b00) || ({2'b00, addr_q[31:2]} >= DEPTH_U);

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // The commit edge: erroneous accesses never touch the RAM.
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    err_d   = access_err;
                    mem_we  = we_q && !access_err;
                    rdata_d = (access_err || we_q) ? 32'd0 : mem_q[word_idx];
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // RAM contents deliberately survive reset; mem_we is low whenever reset holds the FSM idle.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb_q[i]) begin
                    mem_q[word_idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_wait_responder.sv
// Directed bench for mem_wait_responder: three instances with 2, 0 and 15 wait states.
// Instance 0 covers data/lanes/errors/backpressure/reset; 1 and 2 cover latency extremes.
module tb_mem_wait_responder;

    logic        clk;
    logic        reset;
    logic        reqValid [3];
    logic        reqReady [3];
    logic        reqWe    [3];
    logic [31:0] reqAddr  [3];
    logic [31:0] reqWdata [3];
    logic [3:0]  reqWstrb [3];
    logic        rspValid [3];
    logic        rspReady [3];
    logic [31:0] rspRdata [3];
    logic        rspErr   [3];

    int compared   = 0;
    int mismatched = 0;
    int waitOf [3] = '{2, 0, 15};

    mem_wait_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(reqValid[0]), .req_ready(reqReady[0]), .req_we(reqWe[0]),
        .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]), .req_wstrb(reqWstrb[0]),
        .rsp_valid(rspValid[0]), .rsp_ready(rspReady[0]),
        .rsp_rdata(rspRdata[0]), .rsp_err(rspErr[0])
    );

    mem_wait_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(reqValid[1]), .req_ready(reqReady[1]), .req_we(reqWe[1]),
        .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]), .req_wstrb(reqWstrb[1]),
        .rsp_valid(rspValid[1]), .rsp_ready(rspReady[1]),
        .rsp_rdata(rspRdata[1]), .rsp_err(rspErr[1])
    );

    mem_wait_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(15)) dut2 (
        .clk(clk), .reset(reset),
        .req_valid(reqValid[2]), .req_ready(reqReady[2]), .req_we(reqWe[2]),
        .req_addr(reqAddr[2]), .req_wdata(reqWdata[2]), .req_wstrb(reqWstrb[2]),
        .rsp_valid(rspValid[2]), .rsp_ready(rspReady[2]),
        .rsp_rdata(rspRdata[2]), .rsp_err(rspErr[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
        end
    endtask

    // One complete access on instance idx; holdCycles > 0 stalls the response and
    // fires an ignored write to 0x30 while the responder is busy.
    task automatic applyStimulus(input int idx, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] wstrb,
                                 input logic [31:0] expRdata, input logic expErr,
                                 input int holdCycles, input string tag);
        int lat;
        logic [31:0] heldRdata;
        logic heldErr;
        @(negedge clk);
        checkOutput({tag, " req_ready idle"}, 32'(reqReady[idx]), 32'd1);
        reqWe[idx]    = we;
        reqAddr[idx]  = addr;
        reqWdata[idx] = wdata;
        reqWstrb[idx] = wstrb;
        reqValid[idx] = 1'b1;
        @(posedge clk);
        #1;
        reqValid[idx] = 1'b0;
        reqAddr[idx]  = 32'hFFFF_FFFC;
        reqWdata[idx] = 32'h0BAD_0BAD;
        checkOutput({tag, " req_ready after accept"}, 32'(reqReady[idx]), 32'd0);
        lat = 0;
        while (!rspValid[idx] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({tag, " latency"}, 32'(lat), 32'(waitOf[idx] + 1));
        checkOutput({tag, " rdata"}, rspRdata[idx], expRdata);
        checkOutput({tag, " err"}, 32'(rspErr[idx]), 32'(expErr));
        heldRdata = rspRdata[idx];
        heldErr   = rspErr[idx];
        for (int k = 0; k < holdCycles; k++) begin
            if (k == 0) begin
                reqWe[idx]    = 1'b1;
                reqAddr[idx]  = 32'h30;
                reqWdata[idx] = 32'h5555_5555;
                reqWstrb[idx] = 4'b1111;
                reqValid[idx] = 1'b1;
            end
            @(posedge clk);
            #1;
            reqValid[idx] = 1'b0;
            checkOutput($sformatf("%s hold%0d valid", tag, k), 32'(rspValid[idx]), 32'd1);
            checkOutput($sformatf("%s hold%0d rdata", tag, k), rspRdata[idx], heldRdata);
            checkOutput($sformatf("%s hold%0d err", tag, k), 32'(rspErr[idx]), 32'(heldErr));
            checkOutput($sformatf("%s hold%0d req_ready", tag, k), 32'(reqReady[idx]), 32'd0);
        end
        @(negedge clk);
        rspReady[idx] = 1'b1;
        @(posedge clk);
        #1;
        rspReady[idx] = 1'b0;
        checkOutput({tag, " valid after accept"}, 32'(rspValid[idx]), 32'd0);
        checkOutput({tag, " req_ready back"}, 32'(reqReady[idx]), 32'd1);
        checkOutput({tag, " rdata cleared"}, rspRdata[idx], 32'd0);
        checkOutput({tag, " err cleared"}, 32'(rspErr[idx]), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            reqValid[i] = 1'b0;
            reqWe[i]    = 1'b0;
            reqAddr[i]  = 32'd0;
            reqWdata[i] = 32'd0;
            reqWstrb[i] = 4'd0;
            rspReady[i] = 1'b0;
        end
        #2;
        checkOutput("reset req_ready", 32'(reqReady[0]), 32'd1);
        checkOutput("reset rsp_valid", 32'(rspValid[0]), 32'd0);
        checkOutput("reset rsp_rdata", rspRdata[0], 32'd0);
        checkOutput("reset rsp_err", 32'(rspErr[0]), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        applyStimulus(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'b1111, 32'd0, 1'b0, 0, "wr10");
        applyStimulus(0, 1'b0, 32'h10, 32'd0, 4'd0, 32'hDEAD_BEEF, 1'b0, 0, "rd10");
        applyStimulus(0, 1'b1, 32'h10, 32'h0000_00AA, 4'b0001, 32'd0, 1'b0, 0, "wrLane0");
        applyStimulus(0, 1'b1, 32'h10, 32'h1200_0000, 4'b1000, 32'd0, 1'b0, 0, "wrLane3");
        applyStimulus(0, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0000, 32'd0, 1'b0, 0, "wrNoStrb");
        applyStimulus(0, 1'b0, 32'h10, 32'd0, 4'd0, 32'h12AD_BEAA, 1'b0, 0, "rdLanes");

        applyStimulus(0, 1'b0, 32'h13, 32'd0, 4'd0, 32'd0, 1'b1, 0, "rdMisalign");
        applyStimulus(0, 1'b1, 32'h12, 32'h7777_7777, 4'b1111, 32'd0, 1'b1, 0, "wrMisalign");
        applyStimulus(0, 1'b0, 32'h10, 32'd0, 4'd0, 32'h12AD_BEAA, 1'b0, 0, "rdAfterErr");
        applyStimulus(0, 1'b0, 32'h400, 32'd0, 4'd0, 32'd0, 1'b1, 0, "rdRange");
        applyStimulus(0, 1'b0, 32'h3FC, 32'd0, 4'd0, 32'hXXXX_XXXX, 1'b0, 0, "rdLastWord");

        applyStimulus(0, 1'b1, 32'h30, 32'h0000_0000, 4'b1111, 32'd0, 1'b0, 0, "wr30");
        applyStimulus(0, 1'b0, 32'h10, 32'd0, 4'd0, 32'h12AD_BEAA, 1'b0, 5, "rdStall");
        applyStimulus(0, 1'b0, 32'h30, 32'd0, 4'd0, 32'h0000_0000, 1'b0, 0, "rdIgnored");

        applyStimulus(0, 1'b1, 32'h20, 32'h1111_1111, 4'b1111, 32'd0, 1'b0, 0, "wr20");
        @(negedge clk);
        reqWe[0]    = 1'b1;
        reqAddr[0]  = 32'h20;
        reqWdata[0] = 32'hCAFE_F00D;
        reqWstrb[0] = 4'b1111;
        reqValid[0] = 1'b1;
        @(posedge clk);
        #1;
        reqValid[0] = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("midReset req_ready", 32'(reqReady[0]), 32'd1);
        checkOutput("midReset rsp_valid", 32'(rspValid[0]), 32'd0);
        checkOutput("midReset rsp_rdata", rspRdata[0], 32'd0);
        checkOutput("midReset rsp_err", 32'(rspErr[0]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("postReset req_ready", 32'(reqReady[0]), 32'd1);
        applyStimulus(0, 1'b0, 32'h20, 32'd0, 4'd0, 32'h1111_1111, 1'b0, 0, "rd20");

        for (int d = 1; d < 3; d++) begin
            for (int i = 0; i < 10; i++) begin
                applyStimulus(d, 1'b1, 32'h40 + 32'(i) * 4, 32'hC0DE_0000 + 32'(i), 4'b1111,
                              32'd0, 1'b0, 0, $sformatf("dut%0d wr%0d", d, i));
            end
            for (int i = 0; i < 10; i++) begin
                applyStimulus(d, 1'b0, 32'h40 + 32'(i) * 4, 32'd0, 4'd0,
                              32'hC0DE_0000 + 32'(i), 1'b0, 0, $sformatf("dut%0d rd%0d", d, i));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
